// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-array writeback arbiter.
// Result payload is rd index plus XLEN-wide data.
package wb_write_arbiter_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_result_t;

  // One-hot mask bit for a register index.
  function automatic logic [NUM_REGS-1:0] rd_bit(input logic [REG_IDX_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO for long-path results; pointers carry an extra MSB to tell full from empty.
// Push is ignored when full, pop is ignored when empty.
module wb_result_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  wb_result_t data_i,
  input  logic       pop_i,
  output wb_result_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  wb_result_t     mem_q [Depth];
  logic           do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
               (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    data_o = mem_q[rd_ptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/wb_write_arbiter_fifo.sv
// Pending-rd mask tracker used by the arbiter top; the result FIFO itself is in
// rtl/wb_result_fifo.sv.
module wb_write_arbiter_fifo
  import wb_write_arbiter_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_i,
  input  logic [REG_IDX_W-1:0] set_rd_i,
  input  logic                 clr_i,
  input  logic [REG_IDX_W-1:0] clr_rd_i,
  output logic [NUM_REGS-1:0]  mask_o
);

  logic [NUM_REGS-1:0] mask_q, mask_d;

  // Clear before set so a freshly accepted result to a just-retired rd stays pending.
  always_comb begin
    mask_d = mask_q;
    if (clr_i) begin
      mask_d = mask_d & ~rd_bit(clr_rd_i);
    end
    if (set_i) begin
      mask_d = mask_d | rd_bit(set_rd_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask_o = mask_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU/MEM and long-path writeback into one register-array write per cycle.
// Optional WB_LONG_BYPASS_EN: a long result skips the empty FIFO when the ALU is idle.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ALU_VALID,
  input  logic [REG_IDX_W-1:0] ALU_RD,
  input  logic [XLEN-1:0]      ALU_DATA,
  output logic                 ALU_STALL,
  input  logic                 LONG_VALID,
  input  logic [REG_IDX_W-1:0] LONG_RD,
  input  logic [XLEN-1:0]      LONG_DATA,
  output logic                 LONG_READY,
  output logic                 RD_WB_VALID,
  output logic [REG_IDX_W-1:0] RD_WB,
  output logic [XLEN-1:0]      DATA_OUT,
  output logic [NUM_REGS-1:0]  PENDING_MASK
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  logic                 wb_valid_q, wb_valid_d;
  logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic                 wb_long_q, wb_long_d;
  logic [StarveW-1:0]   starve_q, starve_d;

  logic       alu_win, long_acc, bypass;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_result_t fifo_in, fifo_head;

  assign LONG_READY = !fifo_full && !RST;
  assign fifo_in    = '{rd: LONG_RD, data: LONG_DATA};

  always_comb begin
    alu_win  = ALU_VALID && (ALU_RD != '0);
    long_acc = LONG_VALID && LONG_READY;
    fifo_pop = !alu_win && !fifo_empty;
`ifdef WB_LONG_BYPASS_EN
    bypass   = fifo_empty && !alu_win && long_acc && (LONG_RD != '0);
`else
    bypass   = 1'b0;
`endif
    // rd==0 long results complete the handshake but are dropped here.
    fifo_push = long_acc && (LONG_RD != '0) && !bypass;

    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_long_d  = 1'b0;
    if (alu_win) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = ALU_RD;
      wb_data_d  = ALU_DATA;
    end else if (fifo_pop) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = fifo_head.rd;
      wb_data_d  = fifo_head.data;
      wb_long_d  = 1'b1;
    end else if (bypass) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = LONG_RD;
      wb_data_d  = LONG_DATA;
    end

    // Saturates so a misbehaving ALU cannot re-trigger the stall pulse.
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != StarveW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign ALU_STALL = (starve_q == StarveW'(STARVE_MAX - 1)) && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_long_q  <= 1'b0;
      starve_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_long_q  <= wb_long_d;
      starve_q   <= starve_d;
    end
  end

  assign RD_WB_VALID = wb_valid_q;
  assign RD_WB       = wb_rd_q;
  assign DATA_OUT    = wb_data_q;

  wb_result_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (fifo_push),
    .data_i  (fifo_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A long result stays pending through the cycle its write is presented.
  wb_write_arbiter_fifo u_mask (
    .clk_i    (CLK),
    .rst_i    (RST),
    .set_i    (fifo_push),
    .set_rd_i (LONG_RD),
    .clr_i    (wb_valid_q && wb_long_q),
    .clr_rd_i (wb_rd_q),
    .mask_o   (PENDING_MASK)
  );

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with a write scoreboard keyed by rd.
module tb_wb_write_arbiter;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, long_valid;
  logic [4:0]  alu_rd, long_rd;
  logic [63:0] alu_data, long_data;
  logic        alu_stall, long_ready, rd_wb_valid;
  logic [4:0]  rd_wb;
  logic [63:0] data_out;
  logic [31:0] pending_mask;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  wb_write_arbiter #(
    .FIFO_DEPTH (4),
    .STARVE_MAX (8)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .ALU_VALID    (alu_valid),
    .ALU_RD       (alu_rd),
    .ALU_DATA     (alu_data),
    .ALU_STALL    (alu_stall),
    .LONG_VALID   (long_valid),
    .LONG_RD      (long_rd),
    .LONG_DATA    (long_data),
    .LONG_READY   (long_ready),
    .RD_WB_VALID  (rd_wb_valid),
    .RD_WB        (rd_wb),
    .DATA_OUT     (data_out),
    .PENDING_MASK (pending_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [63:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    long_valid = 1'b0;
    long_rd    = '0;
    long_data  = '0;
  endtask

  // Scoreboard: every presented write must match an outstanding expected result.
  always @(negedge clk) begin
    int idx;
    if (rd_wb_valid === 1'b1) begin
      idx = -1;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (idx < 0 && exp_q[k].rd == rd_wb) idx = k;
      end
      n_vec++;
      assert (idx >= 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed write rd %0d data %0h expected no write",
               rd_wb, data_out);
      end
      if (idx >= 0) begin
        n_vec++;
        assert (data_out === exp_q[idx].data) else begin
          n_err++;
          $error("FAIL sb_data rd%0d: observed %0h expected %0h", rd_wb, data_out,
                 exp_q[idx].data);
        end
        exp_q.delete(idx);
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(rd_wb_valid), 64'd0);
    chk("rst_rd", 64'(rd_wb), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_stall", 64'(alu_stall), 64'd0);
    chk("rst_ready_low", 64'(long_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(long_ready), 64'd1);

    // Single ALU write, latency 1.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
    push_exp(5'd5, 64'hDEAD_BEEF);
    tick();
    idle_inputs();
    chk("alu_valid", 64'(rd_wb_valid), 64'd1);
    chk("alu_rd", 64'(rd_wb), 64'd5);
    chk("alu_data", data_out, 64'hDEAD_BEEF);
    chk("alu_mask", 64'(pending_mask), 64'd0);
    tick();
    chk("alu_idle_after", 64'(rd_wb_valid), 64'd0);
    chk("hold_rd", 64'(rd_wb), 64'd5);

    // Lone long result with ALU idle.
    long_valid = 1'b1; long_rd = 5'd7; long_data = 64'h1234;
    push_exp(5'd7, 64'h1234);
    tick();
    idle_inputs();
`ifdef WB_LONG_BYPASS_EN
    chk("long_byp_valid", 64'(rd_wb_valid), 64'd1);
    chk("long_byp_rd", 64'(rd_wb), 64'd7);
    chk("long_byp_mask", 64'(pending_mask), 64'd0);
    tick();
    chk("long_byp_done", 64'(rd_wb_valid), 64'd0);
    chk("long_byp_mask2", 64'(pending_mask), 64'd0);
`else
    chk("long_n1_valid", 64'(rd_wb_valid), 64'd0);
    chk("long_n1_mask", 64'(pending_mask), 64'h80);
    tick();
    chk("long_n2_valid", 64'(rd_wb_valid), 64'd1);
    chk("long_n2_rd", 64'(rd_wb), 64'd7);
    chk("long_n2_data", data_out, 64'h1234);
    chk("long_n2_mask", 64'(pending_mask), 64'h80);
    tick();
    chk("long_n3_mask", 64'(pending_mask), 64'd0);
`endif

    // Simultaneous ALU and long: ALU first.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3333;
    long_valid = 1'b1; long_rd = 5'd4; long_data = 64'h4444;
    push_exp(5'd3, 64'h3333);
    push_exp(5'd4, 64'h4444);
    tick();
    idle_inputs();
    chk("both_n1_rd", 64'(rd_wb), 64'd3);
    chk("both_n1_mask", 64'(pending_mask), 64'h10);
    tick();
    chk("both_n2_valid", 64'(rd_wb_valid), 64'd1);
    chk("both_n2_rd", 64'(rd_wb), 64'd4);
    tick();
    chk("both_n3_mask", 64'(pending_mask), 64'd0);

    // Fill FIFO under continuous ALU traffic, then starvation stall.
    for (int i = 0; i < 9; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(20 + (i % 8));
      alu_data  = 64'hA000 + 64'(i);
      push_exp(alu_rd, alu_data);
      long_valid = 1'b1;
      long_rd    = (i < 4) ? 5'(10 + i) : 5'd14;
      long_data  = 64'h0BAD_0000_0000_0000 + 64'(long_rd);
      if (i < 4) push_exp(long_rd, long_data);
      chk($sformatf("starve_ready_%0d", i), 64'(long_ready), (i < 4) ? 64'd1 : 64'd0);
      chk($sformatf("starve_stall_%0d", i), 64'(alu_stall), (i == 8) ? 64'd1 : 64'd0);
      tick();
    end
    alu_valid = 1'b0;
    chk("full_mask", 64'(pending_mask), 64'h3C00);
    chk("full_pop_no_push", 64'(long_ready), 64'd0);
    chk("stall_one_cycle", 64'(alu_stall), 64'd0);
    tick();
    long_valid = 1'b0;
    chk("starve_pop_valid", 64'(rd_wb_valid), 64'd1);
    chk("starve_pop_rd", 64'(rd_wb), 64'd10);
    chk("ready_after_pop", 64'(long_ready), 64'd1);
    tick();
    chk("drain_rd11", 64'(rd_wb), 64'd11);
    chk("drain_mask", 64'(pending_mask), 64'h3800);
    tick();
    chk("drain_rd12", 64'(rd_wb), 64'd12);
    tick();
    chk("drain_rd13", 64'(rd_wb), 64'd13);
    tick();
    chk("drain_idle", 64'(rd_wb_valid), 64'd0);
    chk("drain_mask0", 64'(pending_mask), 64'd0);

    // rd==0 from both sources.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
    long_valid = 1'b1; long_rd = 5'd0; long_data = 64'hEEEE;
    chk("rd0_ready", 64'(long_ready), 64'd1);
    tick();
    idle_inputs();
    chk("rd0_n1_valid", 64'(rd_wb_valid), 64'd0);
    chk("rd0_n1_mask", 64'(pending_mask), 64'd0);
    tick();
    chk("rd0_n2_valid", 64'(rd_wb_valid), 64'd0);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      alu_valid  = 1'b1;
      alu_rd     = 5'(21 + i);
      alu_data   = 64'hB000 + 64'(i);
      push_exp(alu_rd, alu_data);
      long_valid = 1'b1;
      long_rd    = 5'(15 + i);
      long_data  = 64'hC000 + 64'(i);
      tick();
    end
    idle_inputs();
    chk("pre_rst_mask", 64'(pending_mask), 64'h38000);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(long_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 64'(rd_wb_valid), 64'd0);
    chk("post_rst_mask", 64'(pending_mask), 64'd0);
    chk("post_rst_ready", 64'(long_ready), 64'd1);
    tick();
    chk("post_rst_no_pop", 64'(rd_wb_valid), 64'd0);
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
